// File: rtl/iterative_muldiv.sv
// Radix-2 iterative multiply / restoring divide unit, one bit per cycle, 64-bit result in hi/lo.
// Optional signed support is compiled in with `define MULDIV_SIGNED_EN (adds the FIX state).
module iterative_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             signedOp,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divByZero,
  output logic [1:0]       stateDbg
);

  // Handshake: start is taken only when the FSM is in IDLE; busy is high from the
  // cycle after acceptance until the result lands; done pulses for one cycle with hi/lo valid.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
`ifdef MULDIV_SIGNED_EN
    , FIX = 2'd3
`endif
  } stateT;

`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  stateT            state;
  logic [CNT_W-1:0] cnt;
  logic             opL;
  logic [WIDTH-1:0] mcand;   // multiplicand or divisor
  logic [WIDTH-1:0] acc;     // product upper half or partial remainder
  logic [WIDTH-1:0] low;     // multiplier / dividend shifting out, product low / quotient shifting in

  logic             signedReq;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic [WIDTH-1:0] divDiff;
  logic             divGe;
  logic [WIDTH-1:0] stepAcc;
  logic [WIDTH-1:0] stepLow;

  assign stateDbg  = state;
  assign signedReq = SIGNED_EN && signedOp;
  assign absA      = (signedReq && opA[WIDTH-1]) ? -opA : opA;
  assign absB      = (signedReq && opB[WIDTH-1]) ? -opB : opB;

  always_comb begin
    mulSum   = {1'b0, acc} + (low[0] ? {1'b0, mcand} : '0);
    divShift = {acc, low[WIDTH-1]};
    divGe    = divShift >= {1'b0, mcand};
    divDiff  = divShift[WIDTH-1:0] - mcand;
    stepAcc  = acc;
    stepLow  = low;
    if (!opL) begin
      stepAcc = mulSum[WIDTH:1];
      stepLow = {mulSum[0], low[WIDTH-1:1]};
    end else if (divGe) begin
      stepAcc = divDiff;
      stepLow = {low[WIDTH-2:0], 1'b1};
    end else begin
      stepAcc = divShift[WIDTH-1:0];
      stepLow = {low[WIDTH-2:0], 1'b0};
    end
  end

`ifdef MULDIV_SIGNED_EN
  logic                 signedL;
  logic                 negA;
  logic                 negB;
  logic [2*WIDTH-1:0]   prodNeg;

  assign prodNeg = -{acc, low};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      opL       <= 1'b0;
      mcand     <= '0;
      acc       <= '0;
      low       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      divByZero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      signedL   <= 1'b0;
      negA      <= 1'b0;
      negB      <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            opL       <= op;
            cnt       <= '0;
            acc       <= '0;
            divByZero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            signedL   <= signedReq;
            negA      <= signedReq && opA[WIDTH-1];
            negB      <= signedReq && opB[WIDTH-1];
`endif
            if (op && (opB == '0)) begin
              // Divide by zero bypasses the iterations entirely.
              hi        <= opA;
              lo        <= '1;
              divByZero <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              mcand <= op ? absB : absA;
              low   <= op ? absA : absB;
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc <= stepAcc;
          low <= stepLow;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
`ifdef MULDIV_SIGNED_EN
            if (signedL) begin
              state <= FIX;
            end else begin
`else
            begin
`endif
              hi    <= stepAcc;
              lo    <= stepLow;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
`ifdef MULDIV_SIGNED_EN
        FIX: begin
          // Magnitude result is corrected here: quotient/product by sign XOR, remainder by dividend sign.
          if (!opL) begin
            {hi, lo} <= (negA ^ negB) ? prodNeg : {acc, low};
          end else begin
            lo <= (negA ^ negB) ? -low : low;
            hi <= negA ? -acc : acc;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
`endif
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
